neopixel_color_regs: RTL and testbench

- Avalon-MM slave register file directly upstream of the neopixel one-wire transmitter.
- Holds a shadow bank the CPU writes and an active bank that drives the transmitter's flat color bus.
- Shadow-to-active transfer is atomic (commit), so a frame never mixes old and new colors.
- Provides a hardware fill sweep that writes one color to every pixel.

---
 rtl/neopixel_color_regs_pkg.sv | 18 +
 rtl/neopixel_color_regs.sv | 129 ++++++++++++
 tb/tb_neopixel_color_regs.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_color_regs_pkg.sv
// Shared register offsets, control-bit positions and sweep-state encoding
// for the neopixel color register file.
package neopixel_color_regs_pkg;

    // Register offsets relative to the pixel count N
    localparam int CTRL_OFS   = 0;
    localparam int FILL_OFS   = 1;
    localparam int STATUS_OFS = 2;

    localparam int COMMIT_BIT = 0;
    localparam int AUTO_BIT   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/neopixel_color_regs.sv
// Avalon-MM register file feeding the neopixel transmitter: CPU-written shadow
// bank, atomically committed active bank, and a hardware fill sweep.
module neopixel_color_regs
    import neopixel_color_regs_pkg::*;
#(
    parameter int NUMBER_OF_NEOPIXEL = 7,
    parameter int ADDR_WIDTH         = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic                            write,
    input  logic [31:0]                     writedata,
    input  logic                            read,
    output logic [31:0]                     readdata,
    output logic                            waitrequest,
    output logic [32*NUMBER_OF_NEOPIXEL-1:0] color
);

    localparam int N  = NUMBER_OF_NEOPIXEL;
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    localparam logic [31:0] CTRL_ADDR   = 32'(N + CTRL_OFS);
    localparam logic [31:0] FILL_ADDR   = 32'(N + FILL_OFS);
    localparam logic [31:0] STATUS_ADDR = 32'(N + STATUS_OFS);
    localparam logic [FW-1:0] LAST_IDX  = FW'(N - 1);

    logic [N-1:0][31:0] shadow_q, shadow_d;
    logic [N-1:0][31:0] active_q, active_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [31:0]        fill_value_q, fill_value_d;
    logic [15:0]        commit_count_q, commit_count_d;
    logic [FW-1:0]      fill_ctr_q, fill_ctr_d;
    logic               auto_commit_q, auto_commit_d;
    state_e             state_q, state_d;

    logic [31:0] addr_ext;
    logic [31:0] rd_mux;
    logic        busy;

    // Full-width compare so out-of-range addresses never alias onto a pixel
    assign addr_ext    = 32'(address);
    assign busy        = (state_q == FILL);
    assign waitrequest = busy;
    assign readdata    = readdata_q;
    assign color       = active_q;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (addr_ext == 32'(i)) rd_mux = shadow_q[i];
        end
        if (addr_ext == CTRL_ADDR)   rd_mux = {30'b0, auto_commit_q, 1'b0};
        if (addr_ext == FILL_ADDR)   rd_mux = fill_value_q;
        if (addr_ext == STATUS_ADDR) rd_mux = {commit_count_q, 15'b0, busy};
    end

    always_comb begin
        shadow_d       = shadow_q;
        active_d       = active_q;
        readdata_d     = readdata_q;
        fill_value_d   = fill_value_q;
        commit_count_d = commit_count_q;
        fill_ctr_d     = fill_ctr_q;
        auto_commit_d  = auto_commit_q;
        state_d        = state_q;

        case (state_q)
            FILL: begin
                for (int i = 0; i < N; i++) begin
                    if (fill_ctr_q == FW'(i)) begin
                        shadow_d[i] = fill_value_q;
                        if (auto_commit_q) active_d[i] = fill_value_q;
                    end
                end
                fill_ctr_d = fill_ctr_q + 1'b1;
                if (fill_ctr_q == LAST_IDX) state_d = IDLE;
            end
            default: begin
                // A write wins over a simultaneous read; readdata then holds
                if (write) begin
                    for (int i = 0; i < N; i++) begin
                        if (addr_ext == 32'(i)) begin
                            shadow_d[i] = writedata;
                            if (auto_commit_q) active_d[i] = writedata;
                        end
                    end
                    if (addr_ext == CTRL_ADDR) begin
                        auto_commit_d = writedata[AUTO_BIT];
                        if (writedata[COMMIT_BIT]) begin
                            active_d       = shadow_q;
                            commit_count_d = commit_count_q + 16'd1;
                        end
                    end
                    if (addr_ext == FILL_ADDR) begin
                        fill_value_d = writedata;
                        fill_ctr_d   = '0;
                        state_d      = FILL;
                    end
                end else if (read) begin
                    readdata_d = rd_mux;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '0;
            active_q       <= '0;
            readdata_q     <= '0;
            fill_value_q   <= '0;
            commit_count_q <= '0;
            fill_ctr_q     <= '0;
            auto_commit_q  <= 1'b0;
            state_q        <= IDLE;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            readdata_q     <= readdata_d;
            fill_value_q   <= fill_value_d;
            commit_count_q <= commit_count_d;
            fill_ctr_q     <= fill_ctr_d;
            auto_commit_q  <= auto_commit_d;
            state_q        <= state_d;
        end
    end

endmodule

// File: tb/tb_neopixel_color_regs.sv
// Randomized self-checking bench for neopixel_color_regs against a
// register-level behavioural model of the shadow/active banks.
module tb_neopixel_color_regs;

    localparam int N  = 7;
    localparam int AW = 8;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   address = '0;
    logic            write = 1'b0;
    logic [31:0]     writedata = '0;
    logic            read = 1'b0;
    logic [31:0]     readdata;
    logic            waitrequest;
    logic [32*N-1:0] color;

    neopixel_color_regs #(.NUMBER_OF_NEOPIXEL(N), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .waitrequest(waitrequest), .color(color)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] sh_m[N];
    logic [31:0] ac_m[N];
    logic        auto_m;
    logic [15:0] cc_m;
    logic [31:0] fv_m;
    logic [31:0] rd_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
        auto_m = 1'b0; cc_m = '0; fv_m = '0; rd_m = '0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a < N)      return sh_m[a];
        if (a == N)     return {30'b0, auto_m, 1'b0};
        if (a == N + 1) return fv_m;
        if (a == N + 2) return {cc_m, 16'b0};
        return 32'h0;
    endfunction

    task automatic model_write(input int a, input logic [31:0] d);
        if (a < N) begin
            sh_m[a] = d;
            if (auto_m) ac_m[a] = d;
        end else if (a == N) begin
            auto_m = d[1];
            if (d[0]) begin
                for (int i = 0; i < N; i++) ac_m[i] = sh_m[i];
                cc_m = cc_m + 16'd1;
            end
        end else if (a == N + 1) begin
            fv_m = d;
            for (int i = 0; i < N; i++) begin
                sh_m[i] = d;
                if (auto_m) ac_m[i] = d;
            end
        end
    endtask

    // Starts and ends at a falling edge; stalls while waitrequest is high
    task automatic bus_xfer(input int a, input logic [31:0] d, input logic w, input logic r);
        int n;
        address = AW'(a); writedata = d; write = w; read = r;
        n = 0;
        while (waitrequest && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("wait_bound", 32'(waitrequest), 32'h0);
        @(posedge clock);
        @(negedge clock);
        write = 1'b0; read = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (waitrequest && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("idle_bound", 32'(waitrequest), 32'h0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus_xfer(a, d, 1'b1, 1'b0);
        model_write(a, d);
        if (a == N + 1) wait_idle();
    endtask

    task automatic rd(input string tag, input int a);
        bus_xfer(a, 32'h0, 1'b0, 1'b1);
        rd_m = model_read(a);
        chk(tag, readdata, rd_m);
    endtask

    task automatic chk_colors(input string tag);
        for (int i = 0; i < N; i++) chk(tag, color[32*i +: 32], ac_m[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wait", 32'(waitrequest), 32'h0);
        chk("rst_rdata", readdata, 32'h0);
        chk_colors("rst_color");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int a, op;
        logic [31:0] d;
        int cnt;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Reset mid-operation
        wr(N, 32'h2);
        wr(1, 32'hDEADBEEF);
        rd("pre_rst_rd", 1);
        do_reset();
        rd("rst_status", N + 2);

        // Shadow isolation and commit
        wr(2, 32'h00FF0000);
        chk("shadow_iso", color[95:64], 32'h0);
        rd("pix2_rd", 2);
        wr(N, 32'h1);
        chk("commit_pix2", color[95:64], 32'h00FF0000);
        rd("status_1", N + 2);
        for (int i = 0; i < 65535; i++) wr(N, 32'h1);
        rd("status_wrap", N + 2);

        // Auto-commit
        wr(N, 32'h2);
        wr(6, 32'h12345678);
        chk("auto_pix6", color[223:192], 32'h12345678);
        rd("ctrl_rd", N);

        // Fill with a back-to-back STATUS read that must stall
        wr(N, 32'h0);
        bus_xfer(N + 1, 32'h0A0B0C0D, 1'b1, 1'b0);
        model_write(N + 1, 32'h0A0B0C0D);
        address = AW'(N + 2); read = 1'b1;
        chk("stall_rdata", readdata, rd_m);
        cnt = 0;
        while (waitrequest && cnt < 20) begin cnt++; @(negedge clock); end
        chk("fill_wait_cycles", 32'(cnt), 32'd7);
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        rd_m = model_read(N + 2);
        chk("fill_status", readdata, rd_m);
        for (int i = 0; i < N; i++) rd("fill_pix", i);
        chk_colors("fill_nocommit");
        wr(N, 32'h1);
        chk_colors("fill_commit");

        // Boundaries: unmapped address, simultaneous read+write
        wr(10, 32'hCAFEF00D);
        rd("addr10_rd", 10);
        rd("ctrl_before_rw", N);
        bus_xfer(0, 32'h5A5A5A5A, 1'b1, 1'b1);
        model_write(0, 32'h5A5A5A5A);
        chk("rw_rdata_hold", readdata, rd_m);
        rd("rw_pix0", 0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op < 4) begin
                wr($urandom_range(0, N - 1), d);
            end else if (op == 4) begin
                wr(N, 32'($urandom_range(0, 3)));
            end else if (op == 5) begin
                if ($urandom_range(0, 3) == 0) wr(N + 1, d);
                else wr($urandom_range(N + 3, 255), d);
            end else if (op == 6) begin
                a = $urandom_range(0, N - 1);
                bus_xfer(a, d, 1'b1, 1'b1);
                model_write(a, d);
                chk("rnd_rw_hold", readdata, rd_m);
            end else begin
                a = (op == 9) ? $urandom_range(0, 255) : $urandom_range(0, N + 3);
                rd("rnd_rd", a);
            end
            chk_colors("rnd_color");
        end

        // Reset during sweep cycle 3
        wr(N, 32'h2);
        for (int i = 0; i < N; i++) wr(i, 32'h11110000 + 32'(i));
        bus_xfer(N + 1, 32'h77777777, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        chk("sweep_busy", 32'(waitrequest), 32'h1);
        do_reset();
        for (int i = 0; i < N; i++) rd("post_abort_pix", i);
        rd("post_abort_fill", N + 1);
        rd("post_abort_status", N + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
